// File: rtl/mdu_if.sv
// mdu_if: EX-stage request/response bundle of the multiply/divide unit.
//   master side (pipeline/bench) drives START, OP, SRCA, SRCB, FLUSH,
//   HILO_READ, HI_WE, LO_WE and WDATA. The slave side (mdu_controller)
//   drives BUSY, STALL, DONE, DIVZERO, HI and LO.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] SRCA;
  logic [WIDTH-1:0] SRCB;
  logic             FLUSH;
  logic             HILO_READ;
  logic             HI_WE;
  logic             LO_WE;
  logic [WIDTH-1:0] WDATA;
  logic             BUSY;
  logic             STALL;
  logic             DONE;
  logic             DIVZERO;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output START, OP, SRCA, SRCB, FLUSH, HILO_READ, HI_WE, LO_WE, WDATA,
    input  BUSY, STALL, DONE, DIVZERO, HI, LO
  );

  modport slave (
    input  START, OP, SRCA, SRCB, FLUSH, HILO_READ, HI_WE, LO_WE, WDATA,
    output BUSY, STALL, DONE, DIVZERO, HI, LO
  );
endinterface

// File: rtl/mdu_controller.sv
// mdu_controller: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   CLK  - clock, all state changes on the rising edge
//   RST  - synchronous active-high reset
//   bus  - mdu_if slave: operation request, flush, MTHI/MTLO writes,
//          HI/LO read hint in; BUSY/STALL/DONE/DIVZERO and HI/LO out.
// One result bit per clock: WIDTH CALC cycles, then one FINISH cycle that
// applies the signs and commits HI/LO together with a one-cycle DONE.
module mdu_controller #(
  parameter int WIDTH = 32
) (
  input  logic  CLK,
  input  logic  RST,
  mdu_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               divz_q, divz_d;     // current op is a zero-divisor divide
  logic [WIDTH-1:0]   mag_q, mag_d;       // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi half, lo half} working register
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  // Two's-complement magnitude or conditional negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic               signed_op_s;
  logic               in_sign_a_s, in_sign_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic               rem_ge_s;
  logic [WIDTH-1:0]   rem_sub_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s;
  logic               res_neg_s;
  logic [2*WIDTH-1:0] mul_res_s, div_res_s;

  // Operand sign capture: OP[0]=1 selects the unsigned variants.
  assign signed_op_s = ~bus.OP[0];
  assign in_sign_a_s = signed_op_s & bus.SRCA[WIDTH-1];
  assign in_sign_b_s = signed_op_s & bus.SRCB[WIDTH-1];

  // Shift-add step: conditionally add into the upper half (carry kept), then
  // shift the whole accumulator right so the next multiplier bit reaches bit 0.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
  assign mul_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Restoring step: remainder gets the next dividend bit; the quotient bit
  // shifts into the freed LSB of the lower half. The remainder stays below
  // the divisor, so the difference always fits in WIDTH bits.
  assign rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge_s   = (rem_sh_s >= {1'b0, mag_q});
  assign rem_sub_s  = rem_sh_s[WIDTH-1:0] - mag_q;
  assign div_step_s = rem_ge_s ? {rem_sub_s, acc_q[WIDTH-2:0], 1'b1}
                               : {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix-up; the remainder follows the dividend's sign.
  assign res_neg_s = sign_a_q ^ sign_b_q;
  assign mul_res_s = res_neg_s ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
  assign div_res_s = {neg_if(sign_a_q, acc_q[2*WIDTH-1:WIDTH]),
                      neg_if(res_neg_s, acc_q[WIDTH-1:0])};

  // Next-state and datapath update for the IDLE/CALC/FINISH sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    divz_d    = divz_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.HI_WE) begin
          hi_d = bus.WDATA;
        end else begin
          hi_d = hi_q;
        end
        if (bus.LO_WE) begin
          lo_d = bus.WDATA;
        end else begin
          lo_d = lo_q;
        end
        if (bus.START && !bus.FLUSH) begin
          op_d      = bus.OP;
          sign_a_d  = in_sign_a_s;
          sign_b_d  = in_sign_b_s;
          divzero_d = 1'b0;
          cnt_d     = CW'(WIDTH - 1);
          if (bus.OP[1] && (bus.SRCB == {WIDTH{1'b0}})) begin
            // Zero divisor: result is fixed, skip the iterations entirely.
            divz_d  = 1'b1;
            acc_d   = {bus.SRCA, {WIDTH{1'b1}}};
            state_d = S_FINISH;
          end else if (bus.OP[1]) begin
            divz_d  = 1'b0;
            mag_d   = neg_if(in_sign_b_s, bus.SRCB);
            acc_d   = {{WIDTH{1'b0}}, neg_if(in_sign_a_s, bus.SRCA)};
            state_d = S_CALC;
          end else begin
            divz_d  = 1'b0;
            mag_d   = neg_if(in_sign_a_s, bus.SRCA);
            acc_d   = {{WIDTH{1'b0}}, neg_if(in_sign_b_s, bus.SRCB)};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[1] ? div_step_s : mul_step_s;
          if (cnt_q == {CW{1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FINISH: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
        end else begin
          if (divz_q) begin
            {hi_d, lo_d} = acc_q;
          end else if (op_q[1]) begin
            {hi_d, lo_d} = div_res_s;
          end else begin
            {hi_d, lo_d} = mul_res_s;
          end
          done_d    = 1'b1;
          divzero_d = divz_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and HI/LO registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divz_q    <= 1'b0;
      mag_q     <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CW{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      divz_q    <= divz_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.STALL   = bus.BUSY & (bus.START | bus.HILO_READ | bus.HI_WE | bus.LO_WE);
  assign bus.DONE    = done_q;
  assign bus.DIVZERO = divzero_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller (WIDTH=32).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mdu_controller;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST;
  int   tests_run = 0;
  int   tests_failed = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_controller #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.START = 1'b0; bus.OP = 2'b00; bus.SRCA = '0; bus.SRCB = '0;
    bus.FLUSH = 1'b0; bus.HILO_READ = 1'b0; bus.HI_WE = 1'b0;
    bus.LO_WE = 1'b0; bus.WDATA = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.START = 1'b1; bus.OP = op; bus.SRCA = a; bus.SRCB = b;
  endtask

  // Steps until DONE (bounded); n = edge index where DONE was seen, 0 if never.
  task automatic wait_done(input int max_edges, output int n, output int busy_n, output int stall_n);
    n = 0; busy_n = 0; stall_n = 0;
    for (int i = 1; i <= max_edges; i++) begin
      step();
      if (bus.BUSY) busy_n++;
      if (bus.STALL) stall_n++;
      if (i == 1) bus.START = 1'b0;
      if (bus.DONE) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    tests_run++; if (bus.DIVZERO !== 1'b0) begin tests_failed++; $display("FAIL reset_divzero: got %b expected 0", bus.DIVZERO); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 00000000", bus.HI); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 00000000", bus.LO); end
  endtask

  task automatic test_multu();
    int n, b, s;
    bus.HILO_READ = 1'b1;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(60, n, b, s);
    tests_run++; if (n !== 34) begin tests_failed++; $display("FAIL multu_latency: got %0d expected 34", n); end
    tests_run++; if (b !== 33) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", b); end
    tests_run++; if (s !== 33) begin tests_failed++; $display("FAIL multu_stall_cycles: got %0d expected 33", s); end
    tests_run++; if (bus.STALL !== 1'b0) begin tests_failed++; $display("FAIL multu_stall_done: got %b expected 0", bus.STALL); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL multu_hi: got %h expected fffffffe", bus.HI); end
    tests_run++; if (bus.LO !== 32'h00000001) begin tests_failed++; $display("FAIL multu_lo: got %h expected 00000001", bus.LO); end
    bus.HILO_READ = 1'b0;
    step();
    tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL multu_done_pulse: got %b expected 0", bus.DONE); end
  endtask

  task automatic test_signed();
    int n, b, s;
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(60, n, b, s);
    tests_run++; if (n !== 34) begin tests_failed++; $display("FAIL mult_latency: got %0d expected 34", n); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_hi: got %h expected ffffffff", bus.HI); end
    tests_run++; if (bus.LO !== 32'hFFFFFFF1) begin tests_failed++; $display("FAIL mult_lo: got %h expected fffffff1", bus.LO); end
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(60, n, b, s);
    tests_run++; if (bus.LO !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL div_q: got %h expected fffffffd", bus.LO); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL div_r: got %h expected ffffffff", bus.HI); end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(60, n, b, s);
    tests_run++; if (bus.LO !== 32'h80000000) begin tests_failed++; $display("FAIL div_minneg_q: got %h expected 80000000", bus.LO); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL div_minneg_r: got %h expected 00000000", bus.HI); end
  endtask

  task automatic test_divzero();
    int n, b, s;
    issue(2'b11, 32'd7, 32'd0);
    wait_done(10, n, b, s);
    tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL divz_latency: got %0d expected 2", n); end
    tests_run++; if (bus.LO !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL divz_lo: got %h expected ffffffff", bus.LO); end
    tests_run++; if (bus.HI !== 32'h7) begin tests_failed++; $display("FAIL divz_hi: got %h expected 00000007", bus.HI); end
    tests_run++; if (bus.DIVZERO !== 1'b1) begin tests_failed++; $display("FAIL divz_flag: got %b expected 1", bus.DIVZERO); end
    step();
    tests_run++; if (bus.DIVZERO !== 1'b1) begin tests_failed++; $display("FAIL divz_flag_hold: got %b expected 1", bus.DIVZERO); end
    issue(2'b01, 32'd2, 32'd3);
    step();
    bus.START = 1'b0;
    tests_run++; if (bus.DIVZERO !== 1'b0) begin tests_failed++; $display("FAIL divz_clear: got %b expected 0", bus.DIVZERO); end
    wait_done(60, n, b, s);
    tests_run++; if (n !== 33) begin tests_failed++; $display("FAIL divz_next_latency: got %0d expected 33", n); end
    tests_run++; if (bus.LO !== 32'd6) begin tests_failed++; $display("FAIL divz_next_lo: got %h expected 00000006", bus.LO); end
  endtask

  task automatic test_flush();
    int n, b, s;
    int done_seen;
    bus.HI_WE = 1'b1; bus.WDATA = 32'h11111111;
    step();
    bus.HI_WE = 1'b0; bus.LO_WE = 1'b1; bus.WDATA = 32'h22222222;
    step();
    bus.LO_WE = 1'b0;
    tests_run++; if (bus.HI !== 32'h11111111) begin tests_failed++; $display("FAIL mthi: got %h expected 11111111", bus.HI); end
    tests_run++; if (bus.LO !== 32'h22222222) begin tests_failed++; $display("FAIL mtlo: got %h expected 22222222", bus.LO); end
    issue(2'b11, 32'd100, 32'd3);
    step();
    bus.START = 1'b0;
    done_seen = 0;
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL flush_busy: got %b expected 1", bus.BUSY); end
    for (int i = 2; i <= 10; i++) begin
      step();
      if (bus.DONE) done_seen++;
      if (i == 5) begin bus.HI_WE = 1'b1; bus.WDATA = 32'hDEADBEEF; end
      if (i == 6) bus.HI_WE = 1'b0;
    end
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL flush_idle: got %b expected 0", bus.BUSY); end
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) done_seen++;
      step();
    end
    tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL flush_no_done: got %0d pulses expected 0", done_seen); end
    tests_run++; if (bus.HI !== 32'h11111111) begin tests_failed++; $display("FAIL flush_hi: got %h expected 11111111", bus.HI); end
    tests_run++; if (bus.LO !== 32'h22222222) begin tests_failed++; $display("FAIL flush_lo: got %h expected 22222222", bus.LO); end
    issue(2'b11, 32'd100, 32'd3);
    wait_done(60, n, b, s);
    tests_run++; if (n !== 34) begin tests_failed++; $display("FAIL divu_latency: got %0d expected 34", n); end
    tests_run++; if (bus.LO !== 32'd33) begin tests_failed++; $display("FAIL divu_q: got %h expected 00000021", bus.LO); end
    tests_run++; if (bus.HI !== 32'd1) begin tests_failed++; $display("FAIL divu_r: got %h expected 00000001", bus.HI); end
  endtask

  task automatic test_reset_midop();
    int done_seen;
    issue(2'b01, 32'd5, 32'd7);
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 10; i++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", bus.BUSY); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_hi: got %h expected 00000000", bus.HI); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_lo: got %h expected 00000000", bus.LO); end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) done_seen++;
      step();
    end
    tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    int n, b, s;
    int e;
    bus.HI_WE = 1'b1; bus.WDATA = 32'hAAAA5555;
    step();
    bus.HI_WE = 1'b0;
    issue(2'b00, 32'd6, 32'hFFFFFFFE);
    step();
    e = 1;
    issue(2'b11, 32'd9, 32'd4);
    bus.HI_WE = 1'b1; bus.WDATA = 32'hDEADBEEF;
    step();
    e = 2;
    bus.HI_WE = 1'b0;
    tests_run++; if (bus.STALL !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall: got %b expected 1", bus.STALL); end
    tests_run++; if (bus.HI !== 32'hAAAA5555) begin tests_failed++; $display("FAIL b2b_mthi_ignored: got %h expected aaaa5555", bus.HI); end
    for (int i = 0; i < 60; i++) begin
      if (bus.DONE) break;
      step();
      e++;
    end
    tests_run++; if (e !== 34) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d expected 34", e); end
    tests_run++; if (bus.HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_mult_hi: got %h expected ffffffff", bus.HI); end
    tests_run++; if (bus.LO !== 32'hFFFFFFF4) begin tests_failed++; $display("FAIL b2b_mult_lo: got %h expected fffffff4", bus.LO); end
    wait_done(60, n, b, s);
    tests_run++; if (n !== 34) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d expected 34", n); end
    tests_run++; if (bus.LO !== 32'd2) begin tests_failed++; $display("FAIL b2b_divu_q: got %h expected 00000002", bus.LO); end
    tests_run++; if (bus.HI !== 32'd1) begin tests_failed++; $display("FAIL b2b_divu_r: got %h expected 00000001", bus.HI); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_divzero();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
